// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// E0-prefixed key decoding is enabled by defining PS2_EXT_KEYS_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  localparam logic [15:0] HK_NEWLINE   = 16'd128;
  localparam logic [15:0] HK_BACKSPACE = 16'd129;
  localparam logic [15:0] HK_LEFT      = 16'd130;
  localparam logic [15:0] HK_UP        = 16'd131;
  localparam logic [15:0] HK_RIGHT     = 16'd132;
  localparam logic [15:0] HK_DOWN      = 16'd133;
  localparam logic [15:0] HK_HOME      = 16'd134;
  localparam logic [15:0] HK_END       = 16'd135;
  localparam logic [15:0] HK_PGUP      = 16'd136;
  localparam logic [15:0] HK_PGDN      = 16'd137;
  localparam logic [15:0] HK_INSERT    = 16'd138;
  localparam logic [15:0] HK_DELETE    = 16'd139;
  localparam logic [15:0] HK_ESC       = 16'd140;
  localparam logic [15:0] HK_F1        = 16'd141;
  localparam logic [15:0] HK_F12       = 16'd152;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code set 2 to Hack key-code lookup.
// E0-prefixed codes map only when PS2_EXT_KEYS_EN is defined.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0]  code,
  input  logic        ext,
  input  logic        shift,
  output logic [15:0] value,
  output logic        mapped
);

  always_comb begin
    value  = '0;
    mapped = 1'b0;
    if (ext) begin
`ifdef PS2_EXT_KEYS_EN
      mapped = 1'b1;
      case (code)
        8'h6B:   value = HK_LEFT;
        8'h75:   value = HK_UP;
        8'h74:   value = HK_RIGHT;
        8'h72:   value = HK_DOWN;
        8'h6C:   value = HK_HOME;
        8'h69:   value = HK_END;
        8'h7D:   value = HK_PGUP;
        8'h7A:   value = HK_PGDN;
        8'h70:   value = HK_INSERT;
        8'h71:   value = HK_DELETE;
        default: mapped = 1'b0;
      endcase
`endif
    end else begin
      mapped = 1'b1;
      case (code)
        8'h1C: value = 16'd65;  8'h32: value = 16'd66;  8'h21: value = 16'd67;
        8'h23: value = 16'd68;  8'h24: value = 16'd69;  8'h2B: value = 16'd70;
        8'h34: value = 16'd71;  8'h33: value = 16'd72;  8'h43: value = 16'd73;
        8'h3B: value = 16'd74;  8'h42: value = 16'd75;  8'h4B: value = 16'd76;
        8'h3A: value = 16'd77;  8'h31: value = 16'd78;  8'h44: value = 16'd79;
        8'h4D: value = 16'd80;  8'h15: value = 16'd81;  8'h2D: value = 16'd82;
        8'h1B: value = 16'd83;  8'h2C: value = 16'd84;  8'h3C: value = 16'd85;
        8'h2A: value = 16'd86;  8'h1D: value = 16'd87;  8'h22: value = 16'd88;
        8'h35: value = 16'd89;  8'h1A: value = 16'd90;
        // Digit row: shifted values follow the US layout symbols.
        8'h16: value = shift ? 16'd33 : 16'd49;
        8'h1E: value = shift ? 16'd64 : 16'd50;
        8'h26: value = shift ? 16'd35 : 16'd51;
        8'h25: value = shift ? 16'd36 : 16'd52;
        8'h2E: value = shift ? 16'd37 : 16'd53;
        8'h36: value = shift ? 16'd94 : 16'd54;
        8'h3D: value = shift ? 16'd38 : 16'd55;
        8'h3E: value = shift ? 16'd42 : 16'd56;
        8'h46: value = shift ? 16'd40 : 16'd57;
        8'h45: value = shift ? 16'd41 : 16'd48;
        8'h29: value = 16'd32;
        8'h5A: value = HK_NEWLINE;
        8'h66: value = HK_BACKSPACE;
        8'h76: value = HK_ESC;
        8'h05: value = HK_F1;
        8'h06: value = 16'd142;
        8'h04: value = 16'd143;
        8'h0C: value = 16'd144;
        8'h03: value = 16'd145;
        8'h0B: value = 16'd146;
        8'h83: value = 16'd147;
        8'h0A: value = 16'd148;
        8'h01: value = 16'd149;
        8'h09: value = 16'd150;
        8'h78: value = 16'd151;
        8'h07: value = HK_F12;
        default: mapped = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver and make/break decoder producing the Hack KBD word.
// Define PS2_EXT_KEYS_EN to decode E0-prefixed navigation keys.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] key,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic        frame_err
);

  localparam int TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_prev;
  logic        fall;
  logic        dat;

  ps2_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic [TW-1:0] timer;

  logic        ext;
  logic        brk;
  logic        shift;
  logic [15:0] map_value;
  logic        map_hit;

  // Sync flops reset high so the idle-high bus shows no edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      timer      <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // An edge always beats a simultaneous timeout and reloads the timer.
        timer <= '0;
        case (state)
          IDLE: begin
            if (!dat) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {dat, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= dat;
            state      <= STOP;
          end
          STOP: begin
            if (dat && (^{shift_reg, parity_bit})) begin
              scan_code  <= shift_reg;
              scan_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timer == TIMEOUT_LAST) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          bit_cnt   <= '0;
          timer     <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  ps2_keymap u_keymap (
    .code   (scan_code),
    .ext    (ext),
    .shift  (shift),
    .value  (map_value),
    .mapped (map_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      shift <= 1'b0;
      key   <= '0;
    end else if (scan_valid) begin
      if (scan_code == PS2_EXT) begin
        ext <= 1'b1;
      end else if (scan_code == PS2_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext && (scan_code == PS2_LSHIFT || scan_code == PS2_RSHIFT)) begin
          shift <= ~brk;
        end else if (map_hit) begin
          // A break clears key only if it releases the key being reported.
          if (!brk) key <= map_value;
          else if (key == map_value) key <= '0;
        end
      end
    end
  end

endmodule
